// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forwarding control with a syscall drain FSM.
// Define HAZARD_STATS_EN to add stall/flush event counters.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_rs_d,
  input  logic [4:0] i_rt_d,
  input  logic [4:0] i_rs_e,
  input  logic [4:0] i_rt_e,
  input  logic [4:0] i_write_reg_e,
  input  logic [4:0] i_write_reg_m,
  input  logic [4:0] i_write_reg_w,
  input  logic       i_reg_write_e,
  input  logic       i_reg_write_m,
  input  logic       i_reg_write_w,
  input  logic       i_mem_to_reg_e,
  input  logic       i_mem_to_reg_m,
  input  logic       i_branch_d,
  input  logic       i_pc_src_d,
  input  logic       i_syscall_e,
  output logic       o_stall_f,
  output logic       o_stall_d,
  output logic       o_flush_d,
  output logic       o_flush_e,
  output logic       o_fwd_a_d,
  output logic       o_fwd_b_d,
  output logic [1:0] o_fwd_a_e,
  output logic [1:0] o_fwd_b_e,
  output logic       o_syscall_go
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, DRAIN, FIRE} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic       r_go;
  logic       w_lw, w_br, w_hold;
  // A write to r0 is never a real producer, so it never matches.
  function automatic logic hit(input logic we, input logic [4:0] wr, input logic [4:0] rd);
    return we && (wr != 5'd0) && (wr == rd);
  endfunction
  assign w_lw = i_mem_to_reg_e && (i_rt_e != 5'd0) && (i_rt_e == i_rs_d || i_rt_e == i_rt_d);
  assign w_br = i_branch_d && (hit(i_reg_write_e, i_write_reg_e, i_rs_d) ||
                               hit(i_reg_write_e, i_write_reg_e, i_rt_d) ||
                               hit(i_mem_to_reg_m, i_write_reg_m, i_rs_d) ||
                               hit(i_mem_to_reg_m, i_write_reg_m, i_rt_d));
  assign w_hold = i_rst_n && (w_lw || w_br || r_state != IDLE);
  assign o_stall_f = w_hold;
  assign o_stall_d = w_hold;
  assign o_flush_e = !i_rst_n || w_hold;
  assign o_flush_d = i_rst_n && i_pc_src_d && !w_hold;
  assign o_fwd_a_d = i_rst_n && hit(i_reg_write_m, i_write_reg_m, i_rs_d);
  assign o_fwd_b_d = i_rst_n && hit(i_reg_write_m, i_write_reg_m, i_rt_d);
  assign o_fwd_a_e = !i_rst_n ? 2'b00 : hit(i_reg_write_m, i_write_reg_m, i_rs_e) ? 2'b10 :
                     hit(i_reg_write_w, i_write_reg_w, i_rs_e) ? 2'b01 : 2'b00;
  assign o_fwd_b_e = !i_rst_n ? 2'b00 : hit(i_reg_write_m, i_write_reg_m, i_rt_e) ? 2'b10 :
                     hit(i_reg_write_w, i_write_reg_w, i_rt_e) ? 2'b01 : 2'b00;
  assign o_syscall_go = r_go;
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = i_syscall_e ? DRAIN : IDLE;
    else if (r_state == DRAIN) w_next = (r_cnt == 4'd0) ? FIRE : DRAIN;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_go    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == IDLE && i_syscall_e) ? 4'(DRAIN_CYCLES - 1) :
                 (r_state == DRAIN && r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
      r_go    <= (r_state == DRAIN) && (r_cnt == 4'd0);
    end
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= 32'd0;
      o_flush_cnt <= 32'd0;
    end else begin
      o_stall_cnt <= o_stall_cnt + 32'(o_stall_d);
      o_flush_cnt <= o_flush_cnt + 32'(o_flush_d);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (DRAIN_CYCLES=3).
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic       we_e, we_m, we_w, m2r_e, m2r_m, branch_d, pc_src_d, syscall_e;
  logic       stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, go;
  logic [1:0] fwd_a_e, fwd_b_e;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [10:0] exp_q[$];
  string       tag_q[$];
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
  int unsigned m_stall = 0, m_flush = 0;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs_d(rs_d), .i_rt_d(rt_d), .i_rs_e(rs_e), .i_rt_e(rt_e),
    .i_write_reg_e(wr_e), .i_write_reg_m(wr_m), .i_write_reg_w(wr_w),
    .i_reg_write_e(we_e), .i_reg_write_m(we_m), .i_reg_write_w(we_w),
    .i_mem_to_reg_e(m2r_e), .i_mem_to_reg_m(m2r_m),
    .i_branch_d(branch_d), .i_pc_src_d(pc_src_d), .i_syscall_e(syscall_e),
    .o_stall_f(stall_f), .o_stall_d(stall_d), .o_flush_d(flush_d), .o_flush_e(flush_e),
    .o_fwd_a_d(fwd_a_d), .o_fwd_b_d(fwd_b_d), .o_fwd_a_e(fwd_a_e), .o_fwd_b_e(fwd_b_e),
    .o_syscall_go(go)
`ifdef HAZARD_STATS_EN
    , .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
`endif
  );

  function automatic logic [10:0] ex(input logic st, input logic fd, input logic fe, input logic fad,
                                     input logic fbd, input logic [1:0] fae, input logic [1:0] fbe,
                                     input logic g);
    return {st, st, fd, fe, fad, fbd, fae, fbe, g};
  endfunction

  task automatic clr();
    {rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w} = '0;
    {we_e, we_m, we_w, m2r_e, m2r_m, branch_d, pc_src_d, syscall_e} = '0;
  endtask

  // Push expectation for the cycle just driven, compare at negedge, then move to next cycle.
  task automatic chk(input string tag, input logic [10:0] e);
    logic [10:0] got, want;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    want = exp_q.pop_front();
    t = tag_q.pop_front();
    got = {stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, go};
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", t, got, want);
    end
`ifdef HAZARD_STATS_EN
    if (!rst_n) begin
      m_stall = 0;
      m_flush = 0;
    end
    n_chk++;
    assert (stall_cnt === m_stall && flush_cnt === m_flush) else begin
      n_fail++;
      $error("FAIL %s_cnt: got %0d/%0d expected %0d/%0d", t, stall_cnt, flush_cnt, m_stall, m_flush);
    end
    if (rst_n) begin
      m_stall += int'(want[10]);
      m_flush += int'(want[8]);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    m2r_e = 1; rt_e = 8; rs_d = 8; pc_src_d = 1; we_m = 1; wr_m = 8;
    chk("rst_gate", ex(0, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    rst_n = 1'b1;
    clr(); m2r_e = 1; rt_e = 8; rs_d = 8; pc_src_d = 1;
    chk("lw_stall", ex(1, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    clr(); we_w = 1; wr_w = 8; rs_e = 8;
    chk("lw_fwd_w", ex(0, 0, 0, 0, 0, 2'b01, 2'b00, 0));
    clr(); m2r_e = 1; rt_e = 8; rt_d = 8;
    chk("lw_rt", ex(1, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    clr(); m2r_e = 1; rt_e = 0; rs_d = 0;
    chk("lw_r0", ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    clr(); we_m = 1; we_w = 1; wr_m = 9; wr_w = 9; rs_e = 9; rt_e = 9;
    chk("dbl_fwd", ex(0, 0, 0, 0, 0, 2'b10, 2'b10, 0));
    clr(); we_m = 1; wr_m = 9; rs_e = 9; we_w = 1; wr_w = 7; rt_e = 7;
    chk("mix_fwd", ex(0, 0, 0, 0, 0, 2'b10, 2'b01, 0));
    clr(); we_m = 1; wr_m = 0; rs_e = 0; we_w = 1; wr_w = 0; rt_e = 0;
    chk("r0_fwd", ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    clr(); we_m = 0; wr_m = 9; rs_e = 9;
    chk("m_we0", ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    clr(); branch_d = 1; rs_d = 5; we_e = 1; wr_e = 5; pc_src_d = 1;
    chk("br_stall", ex(1, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    clr(); branch_d = 1; rs_d = 5; we_m = 1; wr_m = 5; pc_src_d = 1;
    chk("br_fwd", ex(0, 1, 0, 1, 0, 2'b00, 2'b00, 0));
    clr(); branch_d = 1; rt_d = 6; m2r_m = 1; we_m = 1; wr_m = 6;
    chk("br_load_m", ex(1, 0, 1, 0, 1, 2'b00, 2'b00, 0));
    clr(); rs_d = 5; we_e = 1; wr_e = 5;
    chk("br_none", ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    clr(); branch_d = 1; we_e = 1; wr_e = 0;
    chk("br_r0", ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    clr(); pc_src_d = 1;
    chk("jump", ex(0, 1, 0, 0, 0, 2'b00, 2'b00, 0));
    clr(); syscall_e = 1;
    chk("sys_c0", ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    pc_src_d = 1;
    chk("sys_c1", ex(1, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    pc_src_d = 0;
    chk("sys_c2", ex(1, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    chk("sys_c3", ex(1, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    chk("sys_c4_go", ex(1, 0, 1, 0, 0, 2'b00, 2'b00, 1));
    syscall_e = 0;
    chk("sys_c5", ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    chk("sys_c6", ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    syscall_e = 1; m2r_e = 1; rt_e = 3; rs_d = 3;
    chk("sys_lw", ex(1, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    clr();
    chk("sys_lw_c1", ex(1, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    rst_n = 1'b0;
    chk("rst_mid", ex(0, 0, 1, 0, 0, 2'b00, 2'b00, 0));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) chk("post_rst", ex(0, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
